uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered, configurable UART transmitter: the next generation of the team's fixed 8N1 transmitter. It accepts words over a valid/ready stream into an internal FIFO and serialises them on `txd`. Frame format and baud divisor are selectable at runtime, and consecutive frames are emitted with no idle gap. It sits between a CPU/CSR or debug-stream source and the board UART pin.

## Interface
- `CLK_HZ`, 200_000_000, clock frequency in Hz.
- `BAUD`, 9600, default baud rate. Default divisor `DEF_DIV = CLK_HZ/BAUD`, which must be ≥2.
- `DATA_BITS`, 8, data bits per frame. Legal range 5..9.
- `FIFO_DEPTH`, 4, FIFO entries. Power of two, ≥2.
- `DIV_W`, 16, width of the divisor counter and of `cfg_divisor`.
- `clk` in 1: the only clock. All logic is on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `cfg_divisor` in DIV_W: clocks per bit. A value <2 selects `DEF_DIV`.
- `cfg_parity` in 2: parity mode. 00 none, 01 even, 10 odd, 11 treated as none.
- `cfg_stop2` in 1: 0 = one stop bit, 1 = two stop bits.
- `s_data` in DATA_BITS: word to transmit.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: the FIFO can accept a word.
- `fifo_level` out $clog2(FIFO_DEPTH+1): number of words currently held.
- `tx_busy` out 1: the serialiser FSM is not in IDLE.
- `tx_done` out 1: one-cycle pulse marking the final cycle of a frame's last stop bit.
- `txd` out 1: serial line, idle high.

## Operation
- **Push.** A word is written on any edge where `s_valid && s_ready`. Words are kept in order. `s_ready = (fifo_level != FIFO_DEPTH)`.
  - There is no write-through bypass when full, even if a pop happens in the same cycle.
  - A simultaneous push and pop leaves `fifo_level` unchanged.
- **Config latch.** `cfg_divisor`, `cfg_parity` and `cfg_stop2` are captured when each frame starts. Changes during a frame take effect on the next frame.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** `txd` = 1. If the FIFO is non-empty, pop the head into the shifter, latch config, load the bit counter with D−1, drive `txd` = 0, and go to START.
  - **START:** lasts D cycles, then go to DATA and drive data bit 0.
  - **DATA:** `DATA_BITS` bits, LSB first, D cycles each. After the last bit, go to PARITY if parity is enabled, else STOP.
  - **PARITY:** D cycles. Even mode sends the XOR of the data bits; odd mode sends its inverse.
  - **STOP:** `txd` = 1 for D cycles, or 2·D cycles if two stop bits are selected. On the final cycle, pulse `tx_done`. Then:
    - if the FIFO is non-empty, pop, latch config and drive `txd` = 0 on the next edge, going straight to START with no idle cycle;
    - otherwise go to IDLE.
- **Bit timing.** The bit counter restarts at every frame start. It is not free-running, so every bit, including the start bit, is exactly D cycles.
- **Output timing.** `txd` is registered and changes only at bit boundaries.
- **Frame length.** (1 + DATA_BITS + P + S)·D cycles, where P is 0 or 1 (parity enabled) and S is 1 or 2 (stop bits).

## Timing
- **Reset values** (from the edge where `rst` = 1):
  - `txd` = 1, `tx_busy` = 0, `tx_done` = 0, `fifo_level` = 0, `s_ready` = 1;
  - FSM goes to IDLE, FIFO pointers are cleared, and pushes while `rst` = 1 are ignored.
- **Reset mid-frame:** the frame is aborted, `txd` = 1 on the next edge, and all FIFO contents are discarded.
- **Latency:** a push at edge N into an empty, idle block gives `fifo_level` = 1 after edge N. At edge N+1, `txd` = 0, `tx_busy` = 1 and `fifo_level` = 0.
- **`tx_busy`:** deasserts on the edge after the final stop-bit cycle, and only if the FIFO is empty.
- **FIFO pointers:** wrap modulo `FIFO_DEPTH`. Full and empty are distinguished by `fifo_level`.

## Test plan
- **8N1 frame.** Divisor 4, parity 00, `cfg_stop2` = 0, push 0x55. Expect `txd` sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles total), one `tx_done` pulse at cycle 40 after the start bit began, and `tx_busy` = 0 on the next edge.
- **Parity.** Divisor 2, push 0x07. Even mode: the parity bit is 1. Odd mode: it is 0. Parity 11 matches parity 00 (frame of 20 cycles).
- **Width and stop bits.** `DATA_BITS` = 7, two stop bits, divisor 3, push 0x41. Expect a 30-cycle frame with bits 0,1,0,0,0,0,0,1,1,1.
- **Back-to-back burst.** `FIFO_DEPTH` = 4, divisor 2, hold `s_valid` = 1 with data 0x10,0x11,… . Expect:
  - `s_ready` low only while `fifo_level` = 4;
  - all words transmitted in order;
  - the first `txd` = 0 of each frame immediately after the previous stop bit, with zero idle cycles.
- **Default and mid-frame config change.** Set `cfg_divisor` = 1: bits must last `DEF_DIV` cycles. Change the divisor from 4 to 8 during frame 1: frame 1 keeps 4 cycles per bit and frame 2 uses 8.
- **Reset mid-frame.** Assert `rst` for 1 cycle during data bit 3 with 3 words queued. Expect `txd` = 1, `fifo_level` = 0 and `tx_busy` = 0 on the next edge, and no further frames.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready FIFO feeding a serialiser with runtime-selectable
// divisor, parity and stop bits; frames are emitted back to back while words are queued.
module uart_tx_fifo #(
  parameter int unsigned CLK_HZ     = 200_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DIV_W-1:0]                   cfg_divisor,
  input  logic [1:0]                         cfg_parity,
  input  logic                               cfg_stop2,
  input  logic [DATA_BITS-1:0]               s_data,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               tx_busy,
  output logic                               tx_done,
  output logic                               txd
);

  localparam int unsigned DEF_DIV = CLK_HZ / BAUD;
  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW    = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]      level_q, level_d;
  state_e               state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d, div_q, div_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_en_q, par_en_d, par_bit_q, par_bit_d, stop2_q, stop2_d;
  logic                 txd_q, txd_d, busy_q, busy_d, done_q, done_d;
  logic                 push, pop, start_frame, fifo_empty;
  logic [DIV_W-1:0]     eff_div;
  logic [DATA_BITS-1:0] head;

  assign s_ready    = (level_q != LvlW'(FIFO_DEPTH));
  assign push       = s_valid && s_ready;
  assign fifo_empty = (level_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign eff_div    = (cfg_divisor < DIV_W'(2)) ? DIV_W'(DEF_DIV) : cfg_divisor;

  assign fifo_level = level_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign txd        = txd_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    stop2_d     = stop2_q;
    txd_d       = txd_q;
    start_frame = 1'b0;

    case (state_q)
      StIdle: begin
        txd_d = 1'b1;
        if (!fifo_empty) start_frame = 1'b1;
      end
      StStart: begin
        if (cnt_q == '0) begin
          state_d = StData;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
          cnt_d   = div_q - DIV_W'(1);
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          cnt_d = div_q - DIV_W'(1);
          if (bit_q == 4'(DATA_BITS - 1)) begin
            if (par_en_q) begin
              state_d = StParity;
              txd_d   = par_bit_q;
            end else begin
              state_d = StStop;
              txd_d   = 1'b1;
              bit_d   = {3'b000, stop2_q};
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      StParity: begin
        if (cnt_q == '0) begin
          state_d = StStop;
          txd_d   = 1'b1;
          bit_d   = {3'b000, stop2_q};
          cnt_d   = div_q - DIV_W'(1);
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      StStop: begin
        // bit_q counts remaining extra stop bits so 2*D never overflows the counter
        if (cnt_q == '0) begin
          if (bit_q != '0) begin
            bit_d = bit_q - 4'd1;
            cnt_d = div_q - DIV_W'(1);
          end else if (!fifo_empty) begin
            start_frame = 1'b1;
          end else begin
            state_d = StIdle;
            txd_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_frame) begin
      state_d   = StStart;
      txd_d     = 1'b0;
      shift_d   = head;
      div_d     = eff_div;
      cnt_d     = eff_div - DIV_W'(1);
      stop2_d   = cfg_stop2;
      par_en_d  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
      par_bit_d = (^head) ^ (cfg_parity == 2'b10);
    end

    pop      = start_frame;
    level_d  = level_q + LvlW'(push) - LvlW'(pop);
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    busy_d   = (state_d != StIdle);
    done_d   = (state_d == StStop) && (cnt_d == '0) && (bit_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      div_q     <= DIV_W'(DEF_DIV);
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      level_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      level_q   <= level_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= s_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted words are queued, and a per-cycle monitor expands
// each word into its ideal bit waveform from the frame rules and compares the line against it.
module tb_uart_tx_fifo;

  localparam int unsigned CLK_HZ  = 1_000_000;
  localparam int unsigned BAUD    = 200_000;
  localparam int unsigned DEF_DIV = CLK_HZ / BAUD;
  localparam int unsigned DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cfg_divisor;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [2:0]  fifo_level;
  logic        tx_busy, tx_done, txd;

  uart_tx_fifo #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .DATA_BITS (8),
    .FIFO_DEPTH(DEPTH),
    .DIV_W     (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_divisor(cfg_divisor),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .fifo_level (fifo_level),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .txd        (txd)
  );

  always #5 clk = ~clk;

  int         checks    = 0;
  int         passes    = 0;
  int         done_cnt  = 0;
  int         max_level = 0;
  logic       mon_en    = 1'b0;
  logic [7:0] exp_q[$];
  logic       wave[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compare this cycle against the model, then plan the next frame if one is due.
  always @(negedge clk) begin : monitor
    logic       e_txd, e_busy, e_done;
    int         d;
    logic [7:0] w;
    logic       bits[$];
    if (mon_en) begin
      if (wave.size() != 0) begin
        e_txd  = wave.pop_front();
        e_busy = 1'b1;
        e_done = (wave.size() == 0);
      end else begin
        e_txd  = 1'b1;
        e_busy = 1'b0;
        e_done = 1'b0;
      end
      check("txd", txd, e_txd);
      check("tx_busy", tx_busy, e_busy);
      check("tx_done", tx_done, e_done);
      check("fifo_level", fifo_level, exp_q.size());
      check("s_ready", s_ready, exp_q.size() != DEPTH);
      if (tx_done) done_cnt++;
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (rst) begin
        exp_q.delete();
        wave.delete();
      end else if (wave.size() == 0 && exp_q.size() != 0) begin
        w = exp_q.pop_front();
        d = (cfg_divisor < 16'd2) ? int'(DEF_DIV) : int'(cfg_divisor);
        bits.delete();
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(w[i]);
        if (cfg_parity == 2'b01) bits.push_back(^w);
        else if (cfg_parity == 2'b10) bits.push_back(~^w);
        bits.push_back(1'b1);
        if (cfg_stop2) bits.push_back(1'b1);
        foreach (bits[i]) for (int k = 0; k < d; k++) wave.push_back(bits[i]);
      end
    end
  end

  // Leaves s_valid high so consecutive calls form a continuous stream.
  task automatic push_word(input logic [7:0] d);
    logic acc;
    acc     = 1'b0;
    s_data  = d;
    s_valid = 1'b1;
    for (int n = 0; n < 2000 && !acc; n++) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      if (acc) exp_q.push_back(d);
    end
    check("push_accepted", acc, 1'b1);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wave.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_in_budget", n < budget, 1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int dc;
    cfg_divisor = 16'd4;
    cfg_parity  = 2'b00;
    cfg_stop2   = 1'b0;
    s_data      = 8'hAA;
    s_valid     = 1'b1;  // must be ignored while in reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", txd, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_level", fifo_level, 3'd0);
    check("rst_ready", s_ready, 1'b1);
    rst     = 1'b0;
    s_valid = 1'b0;
    mon_en  = 1'b1;

    // 8N1 frame with push-to-start latency
    dc = done_cnt;
    push_word(8'h55);
    s_valid = 1'b0;
    check("lat_level1", fifo_level, 3'd1);
    check("lat_txd_idle", txd, 1'b1);
    @(posedge clk);
    #1;
    check("lat_txd_start", txd, 1'b0);
    check("lat_busy", tx_busy, 1'b1);
    check("lat_level0", fifo_level, 3'd0);
    wait_drain(200);
    check("8n1_done_pulses", done_cnt - dc, 1);

    // Parity modes: even, odd, and 11 behaving as none
    cfg_divisor = 16'd2;
    for (int m = 1; m <= 3; m++) begin
      cfg_parity = 2'(m);
      push_word(8'h07);
      s_valid = 1'b0;
      wait_drain(200);
    end

    // Two stop bits
    cfg_parity  = 2'b00;
    cfg_divisor = 16'd3;
    cfg_stop2   = 1'b1;
    push_word(8'h41);
    s_valid = 1'b0;
    wait_drain(200);
    cfg_stop2 = 1'b0;

    // Back-to-back burst filling the FIFO
    cfg_divisor = 16'd2;
    dc          = done_cnt;
    max_level   = 0;
    for (int i = 0; i < 12; i++) push_word(8'h10 + 8'(i));
    s_valid = 1'b0;
    wait_drain(2000);
    check("burst_full_reached", max_level, DEPTH);
    check("burst_frames", done_cnt - dc, 12);

    // Divisor below 2 selects the default
    cfg_divisor = 16'd1;
    push_word(8'hA3);
    s_valid = 1'b0;
    wait_drain(500);
    cfg_divisor = 16'd0;
    push_word(8'h3C);
    s_valid = 1'b0;
    wait_drain(500);

    // Divisor change mid-frame applies to the following frame only
    cfg_divisor = 16'd4;
    push_word(8'h12);
    push_word(8'h34);
    s_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    cfg_divisor = 16'd8;
    wait_drain(500);

    // Randomized words, configurations and gaps
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        cfg_divisor = 16'($urandom_range(0, 6));
        cfg_parity  = 2'($urandom_range(0, 3));
        cfg_stop2   = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 30)) @(posedge clk);
        #1;
      end
      push_word(8'($urandom));
    end
    s_valid = 1'b0;
    wait_drain(20000);

    // Reset during data bit 3 with three words queued
    cfg_divisor = 16'd4;
    cfg_parity  = 2'b00;
    cfg_stop2   = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'hA0 + 8'(i));
    s_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    dc  = done_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_txd", txd, 1'b1);
    check("midrst_level", fifo_level, 3'd0);
    check("midrst_busy", tx_busy, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    check("midrst_no_frames", done_cnt - dc, 0);
    check("midrst_still_idle", txd, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
